// File: rtl/exec_stage_pkg.sv
// exec_stage_pkg: ALU op encodings, default sizes and EX/MEM buffer field offsets
package exec_stage_pkg;
  localparam int N_DEF = 24;
  localparam int M_DEF = 6;
  localparam int OFF_RC = M_DEF * N_DEF;
  localparam int OFF_REGWRITE = OFF_RC + 4;
  localparam int OFF_MEMTOREG = OFF_REGWRITE + 1;
  localparam int OFF_MEMWRITE = OFF_MEMTOREG + 1;
  localparam int OFF_BRANCH = OFF_MEMWRITE + 1;
  localparam int OFF_NEG = OFF_BRANCH + 1;
  localparam int OFF_ZERO = OFF_NEG + 1;
  localparam int OFF_RESULT = OFF_ZERO + 1;
  localparam int OFF_OPCODE = OFF_RESULT + M_DEF * N_DEF;
  localparam int OFF_OPTYPE = OFF_OPCODE + 4;
  localparam int OFF_MODE = OFF_OPTYPE + 2;
  typedef enum logic [3:0] {
    ALU_NOP   = 4'b0000,
    ALU_ADD   = 4'b0001,
    ALU_SUB   = 4'b0010,
    ALU_MUL   = 4'b0011,
    ALU_CMP   = 4'b0100,
    ALU_AND   = 4'b0101,
    ALU_OR    = 4'b0110,
    ALU_XOR   = 4'b0111,
    ALU_SLL   = 4'b1000,
    ALU_SRL   = 4'b1001,
    ALU_PASSB = 4'b1010,
    ALU_PCB   = 4'b1011,
    ALU_PASSA = 4'b1100,
    ALU_VADD  = 4'b1101,
    ALU_VSUB  = 4'b1110,
    ALU_VMUL  = 4'b1111
  } alu_op_e;
endpackage

// File: rtl/exec_stage_if.sv
// exec_stage_if: decode-side operands/forwards/control (master drives) and registered bufferOut (slave drives)
interface exec_stage_if #(
  parameter int N = 24,
  parameter int M = 6,
  parameter int BW = 17 + 2 * M * N
);
  logic en;
  logic [N-1:0] rd1, rd2, rd3, pc, imm;
  logic [M*N-1:0] rdv1, rdv2, rdv3, Forward1, Forward2, Forward3;
  logic Fa, Fb, Fc;
  logic [3:0] aluControl, Rc, opCode;
  logic immSrc, branchFlag, memWrite, memToReg, regWrite, modeSel;
  logic [1:0] opType;
  logic [BW-1:0] bufferOut;
  modport master (
    output en, rd1, rd2, rd3, pc, imm, rdv1, rdv2, rdv3, Forward1, Forward2, Forward3,
    output Fa, Fb, Fc, aluControl, Rc, opCode, immSrc, branchFlag, memWrite, memToReg,
    output regWrite, modeSel, opType,
    input bufferOut
  );
  modport slave (
    input en, rd1, rd2, rd3, pc, imm, rdv1, rdv2, rdv3, Forward1, Forward2, Forward3,
    input Fa, Fb, Fc, aluControl, Rc, opCode, immSrc, branchFlag, memWrite, memToReg,
    input regWrite, modeSel, opType,
    output bufferOut
  );
endinterface

// File: rtl/exec_alu_lane.sv
// exec_alu_lane: one N-bit ALU lane (a, b, pc, op in; y out), PC+B only live in lane 0
module exec_alu_lane
  import exec_stage_pkg::*;
#(
  parameter int N = N_DEF,
  parameter bit LANE0 = 1'b1
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] pc,
  input  alu_op_e      op,
  output logic [N-1:0] y
);
  always_comb begin
    case (op)
      ALU_ADD, ALU_VADD: y = a + b;
      ALU_SUB, ALU_CMP, ALU_VSUB: y = a - b;
      ALU_MUL, ALU_VMUL: y = a * b;
      ALU_AND: y = a & b;
      ALU_OR: y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SLL: y = a << b[4:0];
      ALU_SRL: y = a >> b[4:0];
      ALU_PASSB: y = b;
      ALU_PCB: y = LANE0 ? pc + b : '0;
      ALU_PASSA: y = a;
      default: y = '0;
    endcase
  end
endmodule

// File: rtl/exec_stage.sv
// exec_stage: operand/forward muxing, M-lane ALU, flags and EX/MEM buffer (clk, rst async active-low, bus slave)
module exec_stage
  import exec_stage_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF,
  parameter int BW = 17 + 2 * M * N
) (
  input logic clk,
  input logic rst,
  exec_stage_if.slave bus
);
  logic [M*N-1:0] a, b, st, res_raw, res;
  logic [BW-1:0] buffer_d, buffer_q;
  logic neg, zero;
  always_comb begin
    a = bus.modeSel ? (bus.Fa ? bus.Forward1 : bus.rdv1)
                    : (M*N)'(bus.Fa ? bus.Forward1[N-1:0] : bus.rd1);
    b = bus.modeSel ? (bus.Fb ? bus.Forward2 : bus.rdv2)
                    : (M*N)'(bus.Fb ? bus.Forward2[N-1:0] : (bus.immSrc ? bus.imm : bus.rd2));
    st = bus.modeSel ? (bus.Fc ? bus.Forward3 : bus.rdv3)
                     : (M*N)'(bus.Fc ? bus.Forward3[N-1:0] : bus.rd3);
    res = bus.modeSel ? res_raw : (M*N)'(res_raw[N-1:0]);
    neg = res[N-1];
    zero = res[N-1:0] == '0;
    buffer_d = bus.en ? {bus.modeSel, bus.opType, bus.opCode, res, zero, neg, bus.branchFlag,
                         bus.memWrite, bus.memToReg, bus.regWrite, bus.Rc, st} : buffer_q;
  end
  for (genvar i = 0; i < M; i++) begin : g_lane
    exec_alu_lane #(.N(N), .LANE0(i == 0)) u_lane (
      .a (a[i*N+:N]),
      .b (b[i*N+:N]),
      .pc(bus.pc),
      .op(alu_op_e'(bus.aluControl)),
      .y (res_raw[i*N+:N])
    );
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) buffer_q <= '0;
    else buffer_q <= buffer_d;
  end
  assign bus.bufferOut = buffer_q;
endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: directed and random checks of exec_stage against an arithmetic reference model
module tb_exec_stage;
  localparam int N = 24;
  localparam int M = 6;
  localparam int MN = M * N;
  localparam int BW = 305;
  localparam longint MASK = (longint'(1) << N) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic [BW-1:0] exp_buf = '0;

  exec_stage_if #(.N(N), .M(M)) bus ();
  exec_stage dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [MN-1:0] rv();
    logic [MN-1:0] v;
    for (int k = 0; k < M; k++) v[k*N+:N] = N'($urandom);
    return v;
  endfunction

  function automatic logic [BW-1:0] model();
    logic [MN-1:0] a, b, s, r;
    logic [BW-1:0] o;
    longint x, y, v;
    int sh;
    if (bus.modeSel) begin
      a = bus.Fa ? bus.Forward1 : bus.rdv1;
      b = bus.Fb ? bus.Forward2 : bus.rdv2;
      s = bus.Fc ? bus.Forward3 : bus.rdv3;
    end else begin
      a = '0; b = '0; s = '0;
      a[N-1:0] = bus.Fa ? bus.Forward1[N-1:0] : bus.rd1;
      b[N-1:0] = bus.Fb ? bus.Forward2[N-1:0] : (bus.immSrc ? bus.imm : bus.rd2);
      s[N-1:0] = bus.Fc ? bus.Forward3[N-1:0] : bus.rd3;
    end
    r = '0;
    for (int k = 0; k < M; k++) begin
      x = longint'(a[k*N+:N]);
      y = longint'(b[k*N+:N]);
      sh = int'(b[k*N+:5]);
      v = 0;
      if (bus.modeSel || k == 0) begin
        case (int'(bus.aluControl))
          1, 13: v = x + y;
          2, 4, 14: v = x - y;
          3, 15: v = x * y;
          5: v = x & y;
          6: v = x | y;
          7: v = x ^ y;
          8: v = x * (longint'(1) << sh);
          9: v = x / (longint'(1) << sh);
          10: v = y;
          11: v = (k == 0) ? longint'(bus.pc) + y : 0;
          12: v = x;
          default: v = 0;
        endcase
      end
      v = v & MASK;
      r[k*N+:N] = v[N-1:0];
    end
    o = '0;
    o[143:0] = s;
    o[147:144] = bus.Rc;
    o[148] = bus.regWrite;
    o[149] = bus.memToReg;
    o[150] = bus.memWrite;
    o[151] = bus.branchFlag;
    o[152] = r[N-1];
    o[153] = (r[N-1:0] == 0);
    o[297:154] = r;
    o[301:298] = bus.opCode;
    o[303:302] = bus.opType;
    o[304] = bus.modeSel;
    return o;
  endfunction

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag);
    logic [BW-1:0] nxt;
    nxt = bus.en ? model() : exp_buf;
    @(posedge clk);
    #1;
    exp_buf = nxt;
    check(tag, bus.bufferOut, exp_buf);
  endtask

  task automatic clr();
    bus.en = 1'b1;
    {bus.rd1, bus.rd2, bus.rd3, bus.pc, bus.imm} = '0;
    {bus.rdv1, bus.rdv2, bus.rdv3, bus.Forward1, bus.Forward2, bus.Forward3} = '0;
    {bus.Fa, bus.Fb, bus.Fc, bus.immSrc, bus.branchFlag, bus.memWrite, bus.memToReg} = '0;
    {bus.regWrite, bus.modeSel, bus.opType, bus.opCode, bus.aluControl, bus.Rc} = '0;
  endtask

  initial begin
    clr();
    bus.en = 1'b0;
    rst = 1'b0;
    #1;
    check("pre_capture", bus.bufferOut, '0);
    @(negedge clk);
    rst = 1'b1;
    step("idle_zero");

    @(negedge clk);
    clr();
    bus.rd1 = 24'd1; bus.rd2 = 24'd2; bus.aluControl = 4'b0001;
    step("add_full");
    check("add_res", BW'(bus.bufferOut[177:154]), BW'(24'd3));
    check("add_flags", BW'(bus.bufferOut[153:151]), BW'(3'b000));
    check("add_mode", BW'(bus.bufferOut[304]), BW'(1'b0));

    @(negedge clk);
    clr();
    bus.Rc = 4'd15; bus.regWrite = 1'b1; bus.memToReg = 1'b1; bus.memWrite = 1'b1;
    bus.opCode = 4'd7; bus.opType = 2'd2; bus.modeSel = 1'b1; bus.aluControl = 4'b0001;
    step("pass_full");
    check("pass_rc", BW'(bus.bufferOut[147:144]), BW'(4'd15));
    check("pass_ctl", BW'(bus.bufferOut[150:148]), BW'(3'b111));
    check("pass_opc", BW'(bus.bufferOut[301:298]), BW'(4'd7));
    check("pass_opt", BW'(bus.bufferOut[303:302]), BW'(2'd2));
    check("pass_mode", BW'(bus.bufferOut[304]), BW'(1'b1));

    @(negedge clk);
    clr();
    bus.modeSel = 1'b1; bus.aluControl = 4'b1101;
    for (int k = 0; k < M; k++) begin
      bus.rdv1[k*N+:N] = N'(k + 1);
      bus.rdv2[k*N+:N] = N'(k + 7);
    end
    step("vadd_full");
    for (int k = 0; k < M; k++)
      check("vadd_lane", BW'(bus.bufferOut[154 + k*N +: N]), BW'(8 + 2 * k));
    check("vadd_flags", BW'(bus.bufferOut[153:152]), BW'(2'b00));

    @(negedge clk);
    clr();
    bus.rd1 = 24'd1; bus.rd2 = 24'd4; bus.aluControl = 4'b0100;
    step("cmp_neg_full");
    check("cmp_neg_res", BW'(bus.bufferOut[177:154]), BW'(24'hFFFFFD));
    check("cmp_neg_flags", BW'(bus.bufferOut[153:152]), BW'(2'b01));

    @(negedge clk);
    bus.rd2 = 24'd1;
    step("cmp_eq_full");
    check("cmp_eq_res", BW'(bus.bufferOut[177:154]), BW'(24'd0));
    check("cmp_eq_flags", BW'(bus.bufferOut[153:152]), BW'(2'b10));

    @(negedge clk);
    clr();
    bus.Fa = 1'b1; bus.Forward1[N-1:0] = 24'd19; bus.rd1 = 24'd100; bus.rd2 = 24'd2;
    bus.aluControl = 4'b0001;
    step("fwd_full");
    check("fwd_res", BW'(bus.bufferOut[177:154]), BW'(24'd21));

    @(negedge clk);
    bus.en = 1'b0; bus.rd2 = 24'd50; bus.Rc = 4'd3;
    step("stall1");
    step("stall2");
    check("stall_res", BW'(bus.bufferOut[177:154]), BW'(24'd21));

    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      bus.en = ($urandom_range(0, 3) != 0);
      bus.rd1 = N'($urandom); bus.rd2 = N'($urandom); bus.rd3 = N'($urandom);
      bus.pc = N'($urandom); bus.imm = N'($urandom);
      bus.rdv1 = rv(); bus.rdv2 = rv(); bus.rdv3 = rv();
      bus.Forward1 = rv(); bus.Forward2 = rv(); bus.Forward3 = rv();
      {bus.Fa, bus.Fb, bus.Fc, bus.immSrc, bus.branchFlag} = 5'($urandom);
      {bus.memWrite, bus.memToReg, bus.regWrite, bus.modeSel} = 4'($urandom);
      bus.opType = 2'($urandom); bus.opCode = 4'($urandom);
      bus.aluControl = 4'($urandom); bus.Rc = 4'($urandom);
      if (t % 7 == 0) bus.rd2 = bus.rd1;
      step("rand");
    end

    @(negedge clk);
    bus.en = 1'b1;
    step("pre_rst");
    #2;
    rst = 1'b0;
    #1;
    exp_buf = '0;
    check("async_rst", bus.bufferOut, exp_buf);
    @(posedge clk);
    #1;
    check("rst_hold", bus.bufferOut, exp_buf);
    @(negedge clk);
    rst = 1'b1;
    step("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
